irq_claim_unit: RTL

IRQ_CLAIM_UNIT -- requirements
Module: irq_claim_unit

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_prio_tree.sv | 30 +++
 rtl/irq_claim_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt claim unit.
package irq_pkg;

    localparam int unsigned PrioWidthDefault = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage : irq_pkg

// File: rtl/irq_prio_tree.sv
// Combinational max-priority search over eligible lines; ties resolve to the lowest index.
module irq_prio_tree
    import irq_pkg::*;
#(
    parameter int unsigned NrInputs  = 32,
    parameter int unsigned PrioWidth = PrioWidthDefault,
    localparam int unsigned IdW      = (NrInputs > 1) ? $clog2(NrInputs) : 1
) (
    input  logic [NrInputs-1:0]           elig_i,
    input  logic [NrInputs*PrioWidth-1:0] prio_i,
    output logic                          found_c_o,
    output logic [IdW-1:0]                id_c_o,
    output logic [PrioWidth-1:0]          prio_c_o
);

    // Strict '>' keeps the earliest (lowest-index) line on equal priority.
    always_comb begin
        found_c_o = 1'b0;
        id_c_o    = '0;
        prio_c_o  = '0;
        for (int unsigned i = 0; i < NrInputs; i++) begin
            if (elig_i[i] && (!found_c_o || (prio_i[i*PrioWidth +: PrioWidth] > prio_c_o))) begin
                found_c_o = 1'b1;
                id_c_o    = IdW'(i);
                prio_c_o  = prio_i[i*PrioWidth +: PrioWidth];
            end
        end
    end

endmodule : irq_prio_tree

// File: rtl/irq_claim_unit.sv
// Interrupt pending/claim/complete unit: one offer, one line in service at a time.
// Optional service watchdog is compiled in with IRQ_CLAIM_TIMEOUT_EN.
module irq_claim_unit
    import irq_pkg::*;
#(
    parameter int unsigned NrInputs      = 32,
    parameter int unsigned PrioWidth     = PrioWidthDefault,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdW          = (NrInputs > 1) ? $clog2(NrInputs) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NrInputs-1:0]           irqs_i,
    input  logic [NrInputs-1:0]           ie_i,
    input  logic [NrInputs*PrioWidth-1:0] prio_i,
    input  logic [PrioWidth-1:0]          threshold_i,
    output logic [NrInputs-1:0]           ip_o,
    output logic                          irq_valid_o,
    output logic [IdW-1:0]                irq_id_o,
    output logic [PrioWidth-1:0]          irq_prio_o,
    input  logic                          irq_ready_i,
    input  logic                          complete_i,
    input  logic [IdW-1:0]                complete_id_i,
    output logic                          timeout_o
);

    irq_state_e           state_q, state_d;
    logic [NrInputs-1:0]  ip_q, ip_d;
    logic                 valid_q, valid_d;
    logic [IdW-1:0]       id_q, id_d;
    logic [PrioWidth-1:0] prio_q, prio_d;
    logic                 timeout_q, timeout_d;

    logic [NrInputs-1:0]  elig_c;
    logic                 found_c;
    logic [IdW-1:0]       win_id_c;
    logic [PrioWidth-1:0] win_prio_c;
    logic                 claim_c;
    logic                 wdog_expired_c;

    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NrInputs; i++) begin
            elig_c[i] = ip_q[i] & ie_i[i] & (prio_i[i*PrioWidth +: PrioWidth] > threshold_i);
        end
    end

    irq_prio_tree #(
        .NrInputs  (NrInputs),
        .PrioWidth (PrioWidth)
    ) u_prio_tree (
        .elig_i    (elig_c),
        .prio_i    (prio_i),
        .found_c_o (found_c),
        .id_c_o    (win_id_c),
        .prio_c_o  (win_prio_c)
    );

`ifdef IRQ_CLAIM_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("irq_claim_unit: TimeoutCycles must be at least 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter is zero outside SERVICE, so it restarts on every SERVICE entry.
    assign cnt_d          = (state_q == SERVICE) ? cnt_q + CntW'(1) : '0;
    assign wdog_expired_c = (state_q == SERVICE) && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TimeoutCycles);
    assign wdog_expired_c     = 1'b0;
`endif

    // Next-state, offer capture and claim strobe.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        id_d      = id_q;
        prio_d    = prio_q;
        timeout_d = 1'b0;
        claim_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    id_d    = win_id_c;
                    prio_d  = win_prio_c;
                end
            end
            OFFER: begin
                valid_d = 1'b1;
                if (irq_ready_i) begin
                    state_d = SERVICE;
                    valid_d = 1'b0;
                    claim_c = 1'b1;
                end
            end
            SERVICE: begin
                if (complete_i && (complete_id_i == id_q)) begin
                    state_d = IDLE;
                end else if (wdog_expired_c) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new pulse on the claimed line in the claim cycle wins over the clear.
    assign ip_d = (ip_q & ~(claim_c ? (NrInputs'(1) << id_q) : '0)) | irqs_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ip_q      <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            prio_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            prio_q    <= prio_d;
            timeout_q <= timeout_d;
        end
    end

    assign ip_o        = ip_q;
    assign irq_valid_o = valid_q;
    assign irq_id_o    = id_q;
    assign irq_prio_o  = prio_q;
    assign timeout_o   = timeout_q;

endmodule : irq_claim_unit
